// File: rtl/tempsens_host_pkg.sv
// Shared definitions for the temperature-sensor host reader: controller and
// receiver state encodings, the default read command and UART frame shape.
package tempsens_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } host_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [7:0] DEFAULT_CMD_BYTE = 8'h01;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_STOP_BITS  = 1;
    localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

endpackage

// File: rtl/host_uart_phy.sv
// 8N1 UART serializer/deserializer for the sensor link. DIV clock cycles per
// bit. After reset the transmitter holds the line idle for one full bit-time
// (reported as tx_busy) so the sensor sees a clean idle gap after an abort.
module host_uart_phy
    import tempsens_host_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(DIV);
    localparam int BIT_W = $clog2(UART_FRAME_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(DIV / 2 - 1);
    localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(UART_FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(UART_DATA_BITS - 1);

    logic                    tx_r;
    logic                    tx_active_r;
    logic                    tx_guard_r;
    logic [CNT_W-1:0]        tx_cyc_r;
    logic [BIT_W-1:0]        tx_bit_r;
    logic [UART_DATA_BITS:0] tx_shift_r;

    logic [1:0]       rx_sync_r;
    logic             rx_s;
    logic             rx_prev_r;
    rx_state_t        rx_state_r;
    logic [CNT_W-1:0] rx_cyc_r;
    logic [BIT_W-1:0] rx_bit_r;
    logic [7:0]       rx_shift_r;
    logic [7:0]       rx_data_r;
    logic             rx_ready_r;
    logic             rx_ferr_r;

    assign tx       = tx_r;
    assign tx_busy  = tx_active_r | tx_guard_r;
    assign rx_s     = rx_sync_r[1];
    assign rx_data  = rx_data_r;
    assign rx_ready = rx_ready_r;
    assign rx_ferr  = rx_ferr_r;

    // Transmitter: post-reset idle guard, then start/data/stop serialization LSB first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_r        <= 1'b1;
            tx_active_r <= 1'b0;
            tx_guard_r  <= 1'b1;
            tx_cyc_r    <= {CNT_W{1'b0}};
            tx_bit_r    <= {BIT_W{1'b0}};
            tx_shift_r  <= {(UART_DATA_BITS + 1){1'b1}};
        end else if (tx_guard_r) begin
            if (tx_cyc_r == BIT_LAST) begin
                tx_cyc_r   <= {CNT_W{1'b0}};
                tx_guard_r <= 1'b0;
            end else begin
                tx_cyc_r <= tx_cyc_r + 1'b1;
            end
        end else if (tx_active_r) begin
            if (tx_cyc_r == BIT_LAST) begin
                tx_cyc_r <= {CNT_W{1'b0}};
                if (tx_bit_r == FRAME_LAST) begin
                    tx_active_r <= 1'b0;
                    tx_bit_r    <= {BIT_W{1'b0}};
                    tx_r        <= 1'b1;
                end else begin
                    tx_bit_r   <= tx_bit_r + 1'b1;
                    tx_r       <= tx_shift_r[0];
                    tx_shift_r <= {1'b1, tx_shift_r[UART_DATA_BITS:1]};
                end
            end else begin
                tx_cyc_r <= tx_cyc_r + 1'b1;
            end
        end else if (tx_start) begin
            tx_r        <= 1'b0;
            tx_active_r <= 1'b1;
            tx_shift_r  <= {1'b1, tx_data};
            tx_cyc_r    <= {CNT_W{1'b0}};
            tx_bit_r    <= {BIT_W{1'b0}};
        end
    end

    // Two-flop synchronizer for the asynchronous rx line, preset to idle-high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync_r <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            rx_sync_r <= {rx_sync_r[0], rx};
            rx_prev_r <= rx_s;
        end
    end

    // Receiver: falling edge arms, half-bit confirms start, then mid-bit sampling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_r <= RX_IDLE;
            rx_cyc_r   <= {CNT_W{1'b0}};
            rx_bit_r   <= {BIT_W{1'b0}};
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_ready_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_ready_r <= 1'b0;
            rx_ferr_r  <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    if (rx_prev_r && !rx_s) begin
                        rx_state_r <= RX_START;
                        rx_cyc_r   <= {CNT_W{1'b0}};
                    end
                end
                RX_START: begin
                    if (rx_cyc_r == HALF_LAST) begin
                        rx_cyc_r   <= {CNT_W{1'b0}};
                        rx_bit_r   <= {BIT_W{1'b0}};
                        rx_state_r <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cyc_r <= rx_cyc_r + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cyc_r == BIT_LAST) begin
                        rx_cyc_r   <= {CNT_W{1'b0}};
                        rx_shift_r <= {rx_s, rx_shift_r[7:1]};
                        if (rx_bit_r == DATA_LAST) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 1'b1;
                        end
                    end else begin
                        rx_cyc_r <= rx_cyc_r + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cyc_r == BIT_LAST) begin
                        rx_cyc_r   <= {CNT_W{1'b0}};
                        rx_state_r <= RX_IDLE;
                        if (rx_s) begin
                            rx_data_r  <= rx_shift_r;
                            rx_ready_r <= 1'b1;
                        end else begin
                            rx_ferr_r <= 1'b1;
                        end
                    end else begin
                        rx_cyc_r <= rx_cyc_r + 1'b1;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/tempsens_host_reader.sv
// Host-side reader for a UART temperature sensor: on req, sends CMD_BYTE,
// collects a little-endian 16-bit reply and presents it on sample.
// Optional build macro TEMPSENS_HOST_TIMEOUT_EN adds a per-byte response
// timeout of TIMEOUT_CYC cycles; without it the reader waits indefinitely.
module tempsens_host_reader
    import tempsens_host_pkg::*;
#(
    parameter int         CLK_FREQ    = 10000,
    parameter int         BAUD        = 1000,
    parameter logic [7:0] CMD_BYTE    = DEFAULT_CMD_BYTE,
    parameter int         TIMEOUT_CYC = 40000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rx,
    output logic        tx,
    output logic        busy,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        err
);

    localparam int DIV = CLK_FREQ / BAUD;

    if (DIV < 4 || DIV * BAUD != CLK_FREQ || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("tempsens_host_reader: CLK_FREQ/BAUD must be an integer >= 4 and TIMEOUT_CYC >= 1");
    end

    host_state_t state_r;
    logic        busy_r;
    logic [15:0] sample_r;
    logic        sample_valid_r;
    logic        err_r;
    logic        tx_start_r;
    logic        tx_sent_r;
    logic [7:0]  lo_r;
    logic        tx_busy_s;
    logic [7:0]  rx_data_s;
    logic        rx_ready_s;
    logic        rx_ferr_s;
    logic        tmo_hit_s;

    assign busy         = busy_r;
    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign err          = err_r;

    host_uart_phy #(.DIV(DIV)) u_phy (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start_r),
        .tx_data  (CMD_BYTE),
        .tx_busy  (tx_busy_s),
        .tx       (tx),
        .rx       (rx),
        .rx_data  (rx_data_s),
        .rx_ready (rx_ready_s),
        .rx_ferr  (rx_ferr_s)
    );

`ifdef TEMPSENS_HOST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic [TMO_W-1:0] tmo_r;

    // Count cycles spent waiting for a reply byte; restart on each byte and outside the wait states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if ((state_r == ST_WAIT_LO || state_r == ST_WAIT_HI) && !rx_ready_s && !tmo_hit_s) begin
            tmo_r <= tmo_r + 1'b1;
        end else begin
            tmo_r <= {TMO_W{1'b0}};
        end
    end

    // Timeout fires once the wait counter has run TIMEOUT_CYC cycles.
    always_comb begin
        tmo_hit_s = (tmo_r == TMO_LAST);
    end
`else
    // No timeout hardware: wait states only leave on a byte, a framing error or reset.
    always_comb begin
        tmo_hit_s = 1'b0;
    end
`endif

    // Transaction controller with registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            sample_r       <= 16'h0000;
            sample_valid_r <= 1'b0;
            err_r          <= 1'b0;
            tx_start_r     <= 1'b0;
            tx_sent_r      <= 1'b0;
            lo_r           <= 8'h00;
        end else begin
            tx_start_r     <= 1'b0;
            sample_valid_r <= 1'b0;
            err_r          <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        state_r   <= ST_SEND;
                        busy_r    <= 1'b1;
                        tx_sent_r <= 1'b0;
                    end
                end
                ST_SEND: begin
                    // tx_start_r is still high the cycle before the PHY reports busy, so wait it out.
                    if (!tx_sent_r) begin
                        if (!tx_busy_s) begin
                            tx_start_r <= 1'b1;
                            tx_sent_r  <= 1'b1;
                        end
                    end else if (!tx_start_r && !tx_busy_s) begin
                        state_r <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (rx_ready_s) begin
                        lo_r    <= rx_data_s;
                        state_r <= ST_WAIT_HI;
                    end else if (rx_ferr_s || tmo_hit_s) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_ERR;
                    end
                end
                ST_WAIT_HI: begin
                    if (rx_ready_s) begin
                        sample_r       <= {rx_data_s, lo_r};
                        sample_valid_r <= 1'b1;
                        busy_r         <= 1'b0;
                        state_r        <= ST_DONE;
                    end else if (rx_ferr_s || tmo_hit_s) begin
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_ERR;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                ST_ERR: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
